// File: rtl/kbd_ctrl.sv
// Keyboard controller: PS/2 scan-code decoding into the Hack KBD register, with
// shift/caps tracking and the caps-lock LED command exchange back to the keyboard.
module kbd_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_ready,
    input  logic [7:0]  scan_code,
    output logic [7:0]  lut_code,
    output logic        lut_shift,
    output logic        lut_caps,
    input  logic [7:0]  lut_ascii,
    output logic [15:0] kbd,
    output logic        key_valid,
    output logic        caps_led,
    output logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        ack_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CMD, L_ACK1, L_DATA, L_ACK2} led_state_t;

    dec_state_t dec_state, dec_next;
    led_state_t led_state;

    logic          scan_ready_q;
    logic          accept, in_ack, consume;
    logic          emit, emit_break, emit_ext;
    logic          ev_valid, ev_break, ev_ext;
    logic          shift, caps, caps_down, caps_tog, pending;
    logic          is_shift, is_caps;
    logic [7:0]    key_val;
    logic [8:0]    held_id;
    logic [CW-1:0] ack_cnt;

    // FA/FE replies during an LED exchange belong to the sequencer, not the decoder.
    assign accept   = scan_ready && !scan_ready_q;
    assign in_ack   = (led_state == L_ACK1) || (led_state == L_ACK2);
    assign consume  = accept && in_ack && (scan_code == 8'hFA || scan_code == 8'hFE);
    assign caps_led = caps;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_next   = dec_state;
        emit       = 1'b0;
        emit_break = 1'b0;
        emit_ext   = 1'b0;
        unique case (dec_state)
            D_IDLE: begin
                if (scan_code == 8'hE0)      dec_next = D_EXT;
                else if (scan_code == 8'hF0) dec_next = D_BRK;
                else                         emit = 1'b1;
            end
            D_EXT: begin
                if (scan_code == 8'hF0) begin
                    dec_next = D_EXT_BRK;
                end else begin
                    emit     = 1'b1;
                    emit_ext = 1'b1;
                    dec_next = D_IDLE;
                end
            end
            D_BRK: begin
                emit       = 1'b1;
                emit_break = 1'b1;
                dec_next   = D_IDLE;
            end
            D_EXT_BRK: begin
                emit       = 1'b1;
                emit_break = 1'b1;
                emit_ext   = 1'b1;
                dec_next   = D_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_ready_q <= 1'b0;
            dec_state    <= D_IDLE;
            ev_valid     <= 1'b0;
            ev_break     <= 1'b0;
            ev_ext       <= 1'b0;
            lut_code     <= 8'h00;
            lut_shift    <= 1'b0;
            lut_caps     <= 1'b0;
        end else begin
            scan_ready_q <= scan_ready;
            lut_shift    <= shift;
            lut_caps     <= caps;
            ev_valid     <= 1'b0;
            if (accept && !consume) begin
                dec_state <= dec_next;
                ev_valid  <= emit;
                ev_break  <= emit_break;
                ev_ext    <= emit_ext;
                if (emit) lut_code <= scan_code;
            end
        end
    end

    always_comb begin
        key_val  = 8'h00;
        is_shift = !ev_ext && (lut_code == 8'h12 || lut_code == 8'h59);
        is_caps  = !ev_ext && (lut_code == 8'h58);
        if (ev_ext) begin
            case (lut_code)
                8'h6B:   key_val = 8'd130;
                8'h75:   key_val = 8'd131;
                8'h74:   key_val = 8'd132;
                8'h72:   key_val = 8'd133;
                default: key_val = 8'h00;
            endcase
        end else if (!is_shift && !is_caps) begin
            case (lut_code)
                8'h5A:   key_val = 8'd128;
                8'h66:   key_val = 8'd129;
                8'h76:   key_val = 8'd140;
                default: key_val = lut_ascii;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kbd       <= 16'h0000;
            key_valid <= 1'b0;
            held_id   <= 9'h000;
            shift     <= 1'b0;
            caps      <= 1'b0;
            caps_down <= 1'b0;
            caps_tog  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            caps_tog  <= 1'b0;
            if (ev_valid && !ev_break) begin
                if (is_shift) begin
                    shift <= 1'b1;
                end else if (is_caps) begin
                    // caps_down suppresses retoggling on typematic repeats.
                    if (!caps_down) begin
                        caps     <= !caps;
                        caps_tog <= 1'b1;
                    end
                    caps_down <= 1'b1;
                end else if (key_val != 8'h00) begin
                    kbd       <= {8'h00, key_val};
                    held_id   <= {ev_ext, lut_code};
                    key_valid <= 1'b1;
                end
            end else if (ev_valid) begin
                if (is_shift) begin
                    shift <= 1'b0;
                end else if (is_caps) begin
                    caps_down <= 1'b0;
                end else if ({ev_ext, lut_code} == held_id) begin
                    kbd     <= 16'h0000;
                    held_id <= 9'h000;
                end
            end
        end
    end

    // The timeout counter is cleared with tx_req and reaches ACK_TIMEOUT-1 exactly
    // ACK_TIMEOUT non-busy cycles later, where ack_err is raised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_state <= L_IDLE;
            tx_req    <= 1'b0;
            tx_data   <= 8'h00;
            ack_err   <= 1'b0;
            ack_cnt   <= '0;
            pending   <= 1'b0;
        end else begin
            tx_req  <= 1'b0;
            ack_err <= 1'b0;
            if (caps_tog && led_state != L_IDLE) pending <= 1'b1;
            case (led_state)
                L_IDLE: begin
                    if (caps_tog || pending) begin
                        led_state <= L_CMD;
                        pending   <= 1'b0;
                    end
                end
                L_CMD, L_DATA: begin
                    if (!tx_busy) begin
                        tx_req    <= 1'b1;
                        tx_data   <= (led_state == L_CMD) ? 8'hED : {5'b00000, caps, 2'b00};
                        ack_cnt   <= '0;
                        led_state <= (led_state == L_CMD) ? L_ACK1 : L_ACK2;
                    end
                end
                L_ACK1, L_ACK2: begin
                    if (consume) begin
                        if (scan_code == 8'hFA)
                            led_state <= (led_state == L_ACK1) ? L_DATA : L_IDLE;
                        else
                            led_state <= (led_state == L_ACK1) ? L_CMD : L_DATA;
                    end else if (!tx_busy) begin
                        if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                            ack_err   <= 1'b1;
                            led_state <= L_IDLE;
                        end else begin
                            ack_cnt <= ack_cnt + CW'(1);
                        end
                    end
                end
                default: led_state <= L_IDLE;
            endcase
        end
    end

endmodule
